sample_stream_host: RTL and testbench

Host-side endpoint of the FIR-over-UART link: accepts parallel samples, serialises each into UART bytes for the byte transmitter, and reassembles filtered result bytes from the byte receiver back into parallel words. It sits on the opposite end of the serial cable from the FIR filter system and drives the existing `Tx`/`Rx` byte units. It also enforces a bound on samples in flight.

---
 rtl/sample_link_pkg.sv | 18 +
 rtl/result_assembler.sv | 94 +++++++++
 rtl/sample_stream_host.sv | 136 +++++++++++++
 tb/tb_sample_stream_host.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_link_pkg.sv
// Shared types and constants for the host end of the FIR-over-UART sample link.
package sample_link_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT_BUSY,
        TX_WAIT_IDLE
    } txState_t;

    localparam bit TX_LSB_FIRST = 1'b1;
    localparam bit RX_MSB_FIRST = 1'b1;

    function automatic int calcBytes(input int width, input int uartBits);
        return width / uartBits;
    endfunction

endpackage

// File: rtl/result_assembler.sv
// Reassembles UART result bytes into words; optional inter-byte timeout
// enabled by defining SAMPLE_LINK_TIMEOUT_EN.
module result_assembler
    import sample_link_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int UART_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [UART_BITS-1:0] i_rxData,
    input  logic                 i_rxValid,
    output logic [WIDTH-1:0]     o_rData,
    output logic                 o_rValid,
    output logic                 o_complete,
    output logic                 o_errTimeout
);

    localparam int BYTES = calcBytes(WIDTH, UART_BITS);
    localparam int CW    = $clog2(BYTES + 1);

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_rData;
    logic             r_rValid;
    logic             w_expire;
    logic [CW-1:0]    w_countBase;
    logic             w_complete;
    logic [WIDTH-1:0] w_shifted;

`ifdef SAMPLE_LINK_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    logic [GW-1:0] r_gap;
    logic          r_errTimeout;

    assign w_expire = (r_count != '0) && (r_gap == GW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap        <= '0;
            r_errTimeout <= 1'b0;
        end else begin
            r_errTimeout <= w_expire;
            if (i_rxValid || r_count == '0 || w_expire)
                r_gap <= '0;
            else
                r_gap <= r_gap + GW'(1);
        end
    end

    assign o_errTimeout = r_errTimeout;
`else
    // Without the timeout a partial word waits forever; the comparison only keeps
    // the parameter referenced so both builds share one interface.
    assign w_expire     = 1'b0;
    assign o_errTimeout = (TIMEOUT_CYCLES < 0);
`endif

    // An expiry and a new byte in the same cycle: the byte starts a fresh word.
    assign w_countBase = w_expire ? '0 : r_count;
    assign w_complete  = i_rxValid && (w_countBase == CW'(BYTES - 1));
    assign w_shifted   = RX_MSB_FIRST
                       ? ((r_shift << UART_BITS) | WIDTH'(i_rxData))
                       : ((r_shift >> UART_BITS) | (WIDTH'(i_rxData) << (WIDTH - UART_BITS)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_shift  <= '0;
            r_rData  <= '0;
            r_rValid <= 1'b0;
        end else begin
            r_rValid <= w_complete;
            if (i_rxValid) begin
                r_shift <= w_shifted;
                if (w_complete) begin
                    r_count <= '0;
                    r_rData <= w_shifted;
                end else begin
                    r_count <= w_countBase + CW'(1);
                end
            end else begin
                r_count <= w_countBase;
            end
        end
    end

    assign o_rData    = r_rData;
    assign o_rValid   = r_rValid;
    assign o_complete = w_complete;

endmodule

// File: rtl/sample_stream_host.sv
// Host endpoint of the sample link: serialises samples to the Tx byte unit,
// collects results, bounds samples in flight. Timeout option: SAMPLE_LINK_TIMEOUT_EN.
module sample_stream_host
    import sample_link_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int UART_BITS       = 8,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 100000
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [WIDTH-1:0]                         s_data,
    input  logic                                     s_valid,
    output logic                                     s_ready,
    output logic [WIDTH-1:0]                         r_data,
    output logic                                     r_valid,
    output logic [UART_BITS-1:0]                     tx_data,
    output logic                                     tx_start,
    input  logic                                     tx_busy,
    input  logic [UART_BITS-1:0]                     rx_data,
    input  logic                                     rx_valid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
    output logic                                     err_unsolicited,
    output logic                                     err_timeout
);

    localparam int BYTES = calcBytes(WIDTH, UART_BITS);
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    txState_t             r_state;
    logic [IW-1:0]        r_idx;
    logic [WIDTH-1:0]     r_sample;
    logic [UART_BITS-1:0] r_txData;
    logic                 r_txStart;
    logic                 r_sReady;
    logic [OW-1:0]        r_outstanding;
    logic                 r_errUnsol;
    logic                 w_accept;
    logic                 w_complete;
    logic                 w_lastByte;
    logic                 w_toIdle;
    logic [OW-1:0]        w_outNext;

    function automatic logic [UART_BITS-1:0] selectByte(input logic [WIDTH-1:0] word,
                                                        input logic [IW-1:0]    idx);
        logic [IW-1:0] pos;
        pos = TX_LSB_FIRST ? idx : (IW'(BYTES - 1) - idx);
        return UART_BITS'(word >> (int'(pos) * UART_BITS));
    endfunction

    result_assembler #(
        .WIDTH          (WIDTH),
        .UART_BITS      (UART_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_assembler (
        .clk          (clk),
        .rst          (rst),
        .i_rxData     (rx_data),
        .i_rxValid    (rx_valid),
        .o_rData      (r_data),
        .o_rValid     (r_valid),
        .o_complete   (w_complete),
        .o_errTimeout (err_timeout)
    );

    assign w_accept   = s_valid && r_sReady;
    assign w_lastByte = (r_idx == IW'(BYTES - 1));
    assign w_toIdle   = ((r_state == TX_IDLE) && !w_accept) ||
                        ((r_state == TX_WAIT_IDLE) && !tx_busy && w_lastByte);

    // A completion with nothing in flight leaves the counter at zero.
    always_comb begin
        w_outNext = r_outstanding;
        if (w_accept && !w_complete)
            w_outNext = r_outstanding + OW'(1);
        else if (!w_accept && w_complete && r_outstanding != '0)
            w_outNext = r_outstanding - OW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= TX_IDLE;
            r_idx         <= '0;
            r_sample      <= '0;
            r_txData      <= '0;
            r_txStart     <= 1'b0;
            r_sReady      <= 1'b0;
            r_outstanding <= '0;
            r_errUnsol    <= 1'b0;
        end else begin
            r_outstanding <= w_outNext;
            r_sReady      <= w_toIdle && (w_outNext < OW'(MAX_OUTSTANDING));
            r_txStart     <= 1'b0;
            if (w_complete && r_outstanding == '0)
                r_errUnsol <= 1'b1;
            case (r_state)
                TX_IDLE: begin
                    if (w_accept) begin
                        r_sample  <= s_data;
                        r_idx     <= '0;
                        r_txData  <= selectByte(s_data, '0);
                        r_txStart <= 1'b1;
                        r_state   <= TX_START;
                    end
                end
                TX_START: r_state <= TX_WAIT_BUSY;
                TX_WAIT_BUSY: begin
                    if (tx_busy)
                        r_state <= TX_WAIT_IDLE;
                end
                TX_WAIT_IDLE: begin
                    if (!tx_busy) begin
                        if (w_lastByte) begin
                            r_state <= TX_IDLE;
                        end else begin
                            r_idx     <= r_idx + IW'(1);
                            r_txData  <= selectByte(r_sample, r_idx + IW'(1));
                            r_txStart <= 1'b1;
                            r_state   <= TX_START;
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign s_ready         = r_sReady;
    assign tx_data         = r_txData;
    assign tx_start        = r_txStart;
    assign outstanding     = r_outstanding;
    assign err_unsolicited = r_errUnsol;

endmodule

// File: tb/tb_sample_stream_host.sv
// Scoreboard bench for sample_stream_host: directed link scenarios plus randomized
// traffic against a transaction-level model of bytes, words and samples in flight.
module tb_sample_stream_host;

    localparam int MAX_OUT = 2;
    localparam int TMO     = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] r_data;
    logic        r_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [1:0]  outstanding;
    logic        err_unsolicited;
    logic        err_timeout;

    logic        lastByte = 1'b0;
    logic [7:0]  txExpQ[$];
    logic [15:0] rQ[$];
    int          expOut = 0;
    bit          expErr = 1'b0;
    int          timeoutPulses = 0;
    int          compared = 0;
    int          failed = 0;
    int          busyLen = 10;
    bit          randomBusy = 1'b0;

    sample_stream_host #(
        .WIDTH(16), .UART_BITS(8), .MAX_OUTSTANDING(MAX_OUT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .r_data(r_data), .r_valid(r_valid), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid),
        .outstanding(outstanding), .err_unsolicited(err_unsolicited),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportExpired(input string name);
        compared++;
        failed++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference model and monitors: every negedge compares DUT state and pops
    // the scoreboards, then advances the model by what will happen at the next edge.
    always @(negedge clk) begin
        checkOutput("outstanding", 32'(outstanding), 32'(expOut));
        checkOutput("errUnsolicited", 32'(err_unsolicited), 32'(expErr));
        if (expOut >= MAX_OUT)
            checkOutput("sReadyWhenFull", 32'(s_ready), 32'd0);
        if (r_valid) begin
            if (rQ.size() == 0) begin
                compared++;
                failed++;
                $display("[TB] FAIL rValidUnexpected: got r_data 0x%0h, expected no result", r_data);
            end else begin
                checkOutput("rData", 32'(r_data), 32'(rQ.pop_front()));
            end
        end
        if (tx_start) begin
            if (txExpQ.size() == 0) begin
                compared++;
                failed++;
                $display("[TB] FAIL txStartUnexpected: got byte 0x%0h, expected no start", tx_data);
            end else begin
                checkOutput("txData", 32'(tx_data), 32'(txExpQ.pop_front()));
            end
        end
        if (err_timeout)
            timeoutPulses++;
        if (rst) begin
            expOut = 0;
            expErr = 1'b0;
            txExpQ.delete();
            rQ.delete();
        end else begin
            automatic bit acc  = s_valid && s_ready;
            automatic bit comp = rx_valid && lastByte;
            if (comp && expOut == 0)
                expErr = 1'b1;
            if (acc) begin
                txExpQ.push_back(s_data[7:0]);
                txExpQ.push_back(s_data[15:8]);
            end
            if (acc && !comp)
                expOut++;
            else if (comp && !acc && expOut > 0)
                expOut--;
        end
    end

    // Tx byte unit model: goes busy the cycle after a start pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && !rst) begin
                automatic int n = randomBusy ? int'($urandom_range(1, 6)) : busyLen;
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (n) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] sample);
        int guard = 0;
        s_data  = sample;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            guard++;
            if (guard > 3000) begin
                reportExpired("sampleAccept");
                break;
            end
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic sendResult(input logic [15:0] word);
        rQ.push_back(word);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            rx_data  = word[15-8*i -: 8];
            rx_valid = 1'b1;
            lastByte = (i == 1);
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            lastByte = 1'b0;
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
    endtask

    task automatic waitReady(input string name);
        int guard = 0;
        forever begin
            @(negedge clk);
            if (s_ready || guard > 3000) break;
            guard++;
        end
        checkOutput(name, 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic producer(input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(16'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic responder(input int count);
        for (int i = 0; i < count; i++) begin
            int guard = 0;
            forever begin
                @(negedge clk);
                if (expOut > 0) break;
                guard++;
                if (guard > 3000) begin
                    reportExpired("responderWait");
                    break;
                end
            end
            @(posedge clk);
            #1;
            repeat ($urandom_range(0, 5)) @(posedge clk);
            sendResult(16'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] starting sample_stream_host bench");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstSReady", 32'(s_ready), 32'd0);
        checkOutput("rstTxStart", 32'(tx_start), 32'd0);
        checkOutput("rstTxData", 32'(tx_data), 32'd0);
        checkOutput("rstRValid", 32'(r_valid), 32'd0);
        checkOutput("rstRData", 32'(r_data), 32'd0);
        checkOutput("rstErrTimeout", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("sReadyAfterReset", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;

        // Sample 0x1234 goes out low byte first with a slow Tx unit.
        applyStimulus(16'h1234);
        @(negedge clk);
        checkOutput("sReadyDropAfterAccept", 32'(s_ready), 32'd0);
        waitReady("sReadyReturn");

        // Result 0xABCD arrives high byte first.
        sendResult(16'hABCD);
        repeat (3) @(posedge clk);
        #1;

        // Third sample stalls until a result frees a slot.
        fork
            begin
                applyStimulus(16'hA001);
                applyStimulus(16'hA002);
                applyStimulus(16'hA003);
            end
            begin
                repeat (120) @(posedge clk);
                #1;
                @(negedge clk);
                checkOutput("stallReady", 32'(s_ready), 32'd0);
                checkOutput("stallOutstanding", 32'(outstanding), 32'd2);
                @(posedge clk);
                #1;
                sendResult(16'h0F0F);
            end
        join
        sendResult(16'h1111);
        sendResult(16'h2222);
        waitReady("readyAfterDrain");

        // Result with nothing in flight.
        sendResult(16'h5A5A);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("unsolicitedSticky", 32'(err_unsolicited), 32'd1);
        checkOutput("unsolicitedOutstanding", 32'(outstanding), 32'd0);
        @(posedge clk);
        #1;

`ifdef SAMPLE_LINK_TIMEOUT_EN
        rx_data  = 8'h11;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        checkOutput("timeoutPulse", 32'(timeoutPulses), 32'd1);
        sendResult(16'h2233);
        repeat (3) @(posedge clk);
        #1;
`endif

        // Randomized concurrent traffic.
        randomBusy = 1'b1;
        fork
            producer(15);
            responder(15);
        join
        randomBusy = 1'b0;
        waitReady("readyAfterRandom");

        // Reset while byte 0 of a sample is in the Tx unit.
        applyStimulus(16'hBEEF);
        begin
            int guard = 0;
            while (!tx_busy && guard < 200) begin
                @(posedge clk);
                guard++;
            end
            if (!tx_busy) reportExpired("txBusyBeforeReset");
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midResetTxStart", 32'(tx_start), 32'd0);
        checkOutput("midResetOutstanding", 32'(outstanding), 32'd0);
        checkOutput("midResetSReady", 32'(s_ready), 32'd0);
        begin
            int guard = 0;
            while (tx_busy && guard < 200) begin
                @(posedge clk);
                guard++;
            end
            if (tx_busy) reportExpired("txBusyAfterReset");
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("sReadyAfterMidReset", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(16'h00FF);
        waitReady("readyAfterLast");
        repeat (10) @(posedge clk);
        #1;

        checkOutput("txQueueDrained", 32'(txExpQ.size()), 32'd0);
        checkOutput("resultQueueDrained", 32'(rQ.size()), 32'd0);
`ifdef SAMPLE_LINK_TIMEOUT_EN
        checkOutput("timeoutPulseTotal", 32'(timeoutPulses), 32'd1);
`else
        checkOutput("timeoutPulseTotal", 32'(timeoutPulses), 32'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
